// File: rtl/mbo_rx_frame_ctrl_if.sv
// rtl/mbo_rx_frame_ctrl_if.sv - byte-in / frame-buffer-out bundle for the rx frame controller
interface mbo_rx_frame_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              i_Rx_DV;
    logic [7:0]        i_Rx_Byte;
    logic              i_Rx_Active;
    logic              o_Buf_We;
    logic [ADDR_W-1:0] o_Buf_Addr;
    logic [7:0]        o_Buf_Data;
    logic              o_Frame_Valid;
    logic [7:0]        o_Frame_Len;
    logic              i_Frame_Ack;
    logic              o_Err;
    logic [2:0]        o_Err_Code;
    logic              o_Busy;

    modport master (
        input  i_Rx_DV, i_Rx_Byte, i_Rx_Active, i_Frame_Ack,
        output o_Buf_We, o_Buf_Addr, o_Buf_Data, o_Frame_Valid, o_Frame_Len,
               o_Err, o_Err_Code, o_Busy
    );

    modport slave (
        output i_Rx_DV, i_Rx_Byte, i_Rx_Active, i_Frame_Ack,
        input  o_Buf_We, o_Buf_Addr, o_Buf_Data, o_Frame_Valid, o_Frame_Len,
               o_Err, o_Err_Code, o_Busy
    );
endinterface

// File: rtl/mbo_rx_frame_ctrl.sv
// rtl/mbo_rx_frame_ctrl.sv - SYNC/LEN/payload/CSUM frame parser feeding an external frame buffer
module mbo_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 64,
    parameter int         ADDR_W       = 6,
    parameter int         TIMEOUT_CLKS = 100000,
    parameter int         TO_W         = 24
) (
    input  logic                  i_Clock,
    input  logic                  rst_n,
    mbo_rx_frame_ctrl_if.master   bus
);
    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CSUM    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        acc_q, acc_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        len_q, len_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        data_d;
    logic              fv_d;
    logic [7:0]        flen_d;
    logic              err_d;
    logic [2:0]        code_d;

    logic       dv;
    logic [7:0] rx_byte;
    logic       len_bad;
    logic       to_hit;
    logic       timed;
    logic [7:0] csum_total;

    assign dv         = bus.i_Rx_DV;
    assign rx_byte    = bus.i_Rx_Byte;
    assign len_bad    = (rx_byte == 8'd0) || (rx_byte > 8'(MAX_LEN));
    assign timed      = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
    // An arriving byte always beats the timeout in the same cycle.
    assign to_hit     = timed && !dv && (to_q == TO_W'(TIMEOUT_CLKS - 1));
    assign csum_total = acc_q + rx_byte;

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_HUNT;
            acc_q             <= '0;
            idx_q             <= '0;
            len_q             <= '0;
            to_q              <= '0;
            bus.o_Buf_We      <= 1'b0;
            bus.o_Buf_Addr    <= '0;
            bus.o_Buf_Data    <= '0;
            bus.o_Frame_Valid <= 1'b0;
            bus.o_Frame_Len   <= '0;
            bus.o_Err         <= 1'b0;
            bus.o_Err_Code    <= '0;
            bus.o_Busy        <= 1'b0;
        end else begin
            state_q           <= state_d;
            acc_q             <= acc_d;
            idx_q             <= idx_d;
            len_q             <= len_d;
            to_q              <= to_d;
            bus.o_Buf_We      <= we_d;
            bus.o_Buf_Addr    <= addr_d;
            bus.o_Buf_Data    <= data_d;
            bus.o_Frame_Valid <= fv_d;
            bus.o_Frame_Len   <= flen_d;
            bus.o_Err         <= err_d;
            bus.o_Err_Code    <= code_d;
            bus.o_Busy        <= (state_d != S_HUNT);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HUNT:    if (dv && rx_byte == SYNC_BYTE) state_d = S_LEN;
            S_LEN:     if (dv) state_d = len_bad ? S_HUNT : S_PAYLOAD;
                       else if (to_hit) state_d = S_HUNT;
            S_PAYLOAD: if (dv && idx_q == len_q - 8'd1) state_d = S_CSUM;
                       else if (to_hit) state_d = S_HUNT;
            S_CSUM:    if (dv) state_d = (csum_total == 8'd0) ? S_DONE : S_HUNT;
                       else if (to_hit) state_d = S_HUNT;
            S_DONE:    if (bus.i_Frame_Ack) state_d = S_HUNT;
            default:   state_d = S_HUNT;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        idx_d  = idx_q;
        len_d  = len_q;
        to_d   = to_q;
        we_d   = 1'b0;
        addr_d = bus.o_Buf_Addr;
        data_d = bus.o_Buf_Data;
        fv_d   = bus.o_Frame_Valid;
        flen_d = bus.o_Frame_Len;
        err_d  = 1'b0;
        code_d = bus.o_Err_Code;

        // Idle counter only runs while a frame is in flight; receiver activity freezes it.
        if (timed) begin
            if (dv)
                to_d = '0;
            else if (!bus.i_Rx_Active)
                to_d = to_q + 1'b1;
        end

        case (state_q)
            S_HUNT: begin
                if (dv && rx_byte == SYNC_BYTE) begin
                    acc_d = '0;
                    idx_d = '0;
                    to_d  = '0;
                end
            end
            S_LEN: begin
                if (dv) begin
                    if (len_bad) begin
                        err_d  = 1'b1;
                        code_d = 3'd1;
                    end else begin
                        len_d = rx_byte;
                        acc_d = rx_byte;
                    end
                end else if (to_hit) begin
                    err_d  = 1'b1;
                    code_d = 3'd3;
                end
            end
            S_PAYLOAD: begin
                if (dv) begin
                    we_d   = 1'b1;
                    addr_d = idx_q[ADDR_W-1:0];
                    data_d = rx_byte;
                    acc_d  = acc_q + rx_byte;
                    idx_d  = idx_q + 8'd1;
                end else if (to_hit) begin
                    err_d  = 1'b1;
                    code_d = 3'd3;
                end
            end
            S_CSUM: begin
                if (dv) begin
                    if (csum_total == 8'd0) begin
                        fv_d   = 1'b1;
                        flen_d = len_q;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 3'd2;
                    end
                end else if (to_hit) begin
                    err_d  = 1'b1;
                    code_d = 3'd3;
                end
            end
            S_DONE: begin
                if (bus.i_Frame_Ack) begin
                    fv_d = 1'b0;
                end else if (dv) begin
                    err_d  = 1'b1;
                    code_d = 3'd4;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mbo_rx_frame_ctrl.sv
// tb/tb_mbo_rx_frame_ctrl.sv - scoreboard bench for the rx frame controller
module tb_mbo_rx_frame_ctrl;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int MAX_LEN = 64;
    localparam int ADDR_W  = 6;
    localparam int TO_CLKS = 40;
    localparam int TO_W    = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mbo_rx_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mbo_rx_frame_ctrl #(
        .SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W),
        .TIMEOUT_CLKS(TO_CLKS), .TO_W(TO_W)
    ) dut (
        .i_Clock(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [13:0] wr_q[$];
    logic [2:0]  err_q[$];
    logic [7:0]  flen_q[$];
    logic [7:0]  pl[$];

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: compares every DUT output event against queued expectations.
    logic fv_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_Buf_We) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("buf_write", {bus.o_Buf_Addr, bus.o_Buf_Data}, wr_q.pop_front());
            end
            if (bus.o_Err) begin
                if (err_q.size() == 0) chk("err_unexpected", bus.o_Err_Code, 0);
                else chk("err_code", bus.o_Err_Code, err_q.pop_front());
            end
            if (bus.o_Frame_Valid && !fv_prev) begin
                if (flen_q.size() == 0) chk("fv_unexpected", 1, 0);
                else chk("frame_len", bus.o_Frame_Len, flen_q.pop_front());
            end
        end
        fv_prev = bus.o_Frame_Valid;
    end

    task automatic send_byte(input logic [7:0] b);
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = b;
        @(negedge clk);
        bus.i_Rx_DV   = 1'b0;
    endtask

    // Sends SYNC, LEN, pl[], checksum (optionally corrupted by +1).
    task automatic send_frame(input bit bad_csum);
        logic [7:0] s;
        s = 8'(pl.size());
        send_byte(SYNC);
        send_byte(8'(pl.size()));
        foreach (pl[i]) begin
            wr_q.push_back({6'(i), pl[i]});
            send_byte(pl[i]);
            s = s + pl[i];
        end
        if (bad_csum) err_q.push_back(3'd2);
        else flen_q.push_back(8'(pl.size()));
        send_byte(8'(8'd0 - s + 8'(bad_csum)));
        chk(bad_csum ? "fv_bad_csum" : "fv_one_cycle", bus.o_Frame_Valid, bad_csum ? 0 : 1);
    endtask

    task automatic ack_frame(input bit with_byte);
        bus.i_Frame_Ack = 1'b1;
        bus.i_Rx_DV     = with_byte;
        bus.i_Rx_Byte   = SYNC;
        @(negedge clk);
        bus.i_Frame_Ack = 1'b0;
        bus.i_Rx_DV     = 1'b0;
        chk("fv_after_ack", bus.o_Frame_Valid, 0);
        chk("busy_after_ack", bus.o_Busy, 0);
    endtask

    initial begin
        bit seen;
        int cyc;
        bus.i_Rx_DV = 0; bus.i_Rx_Byte = 0; bus.i_Rx_Active = 0; bus.i_Frame_Ack = 0;
        #2;
        chk("rst_we", bus.o_Buf_We, 0);
        chk("rst_fv", bus.o_Frame_Valid, 0);
        chk("rst_code", bus.o_Err_Code, 0);
        chk("rst_busy", bus.o_Busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(0);
        chk("busy_held", bus.o_Busy, 1);
        ack_frame(0);

        send_frame(1);
        chk("busy_after_bad", bus.o_Busy, 0);
        send_byte(8'h00);
        pl = '{8'hFF};
        send_frame(0);
        ack_frame(0);

        send_byte(SYNC); err_q.push_back(3'd1); send_byte(8'h00);
        send_byte(SYNC); err_q.push_back(3'd1); send_byte(8'h41);
        chk("busy_len_err", bus.o_Busy, 0);
        pl.delete();
        for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(0);
        chk("last_addr", bus.o_Buf_Addr, MAX_LEN - 1);
        ack_frame(0);

        // Timeout: gap with receiver idle.
        send_byte(SYNC); send_byte(8'h02);
        wr_q.push_back({6'd0, 8'h11}); send_byte(8'h11);
        err_q.push_back(3'd3);
        seen = 0; cyc = 0;
        for (int i = 1; i <= TO_CLKS + 4; i++) begin
            @(negedge clk);
            if (bus.o_Err) begin seen = 1; cyc = i; break; end
        end
        chk("to_seen", seen, 1);
        chk("to_cycle", cyc, TO_CLKS);
        chk("to_busy", bus.o_Busy, 0);

        // Same gap with the receiver busy: no timeout.
        send_byte(SYNC); send_byte(8'h02);
        wr_q.push_back({6'd0, 8'h11}); send_byte(8'h11);
        bus.i_Rx_Active = 1'b1;
        repeat (2 * TO_CLKS) @(negedge clk);
        bus.i_Rx_Active = 1'b0;
        chk("active_busy", bus.o_Busy, 1);
        wr_q.push_back({6'd1, 8'h22}); send_byte(8'h22);
        flen_q.push_back(8'd2); send_byte(8'hCB);
        chk("active_fv", bus.o_Frame_Valid, 1);

        // Overrun while holding the frame, then ack racing a strobe.
        err_q.push_back(3'd4);
        send_byte(8'h55);
        chk("ovr_err", bus.o_Err, 1);
        chk("ovr_fv", bus.o_Frame_Valid, 1);
        chk("ovr_len", bus.o_Frame_Len, 2);
        ack_frame(1);
        @(negedge clk);
        chk("ack_race_noerr", bus.o_Err, 0);
        chk("code_held", bus.o_Err_Code, 4);

        // Async reset mid-payload.
        send_byte(SYNC); send_byte(8'h05);
        wr_q.push_back({6'd0, 8'h01}); send_byte(8'h01);
        wr_q.push_back({6'd1, 8'h02}); send_byte(8'h02);
        @(posedge clk); #2; rst_n = 1'b0; #1;
        chk("arst_we", bus.o_Buf_We, 0);
        chk("arst_addr", bus.o_Buf_Addr, 0);
        chk("arst_data", bus.o_Buf_Data, 0);
        chk("arst_busy", bus.o_Busy, 0);
        chk("arst_code", bus.o_Err_Code, 0);
        chk("arst_len", bus.o_Frame_Len, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        pl = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_frame(0);
        ack_frame(0);

        repeat (3) @(negedge clk);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("err_q_empty", err_q.size(), 0);
        chk("flen_q_empty", flen_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
